// File: rtl/reg_context_engine_if.sv
// rtl/reg_context_engine_if.sv - control, register-file and memory bus bundle for the context engine
// master = the engine, slave = the surrounding control unit / regfile / memory.
interface reg_context_engine_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic [4:0]        rf_read_index;
  logic [DATA_W-1:0] rf_read_data;
  logic [4:0]        rf_write_index;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  start, mode, base_addr, rf_read_data, mem_rdata, mem_ready,
    output busy, done, rf_read_index, rf_write_index, rf_write_data,
           rf_write_enable, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output start, mode, base_addr, rf_read_data, mem_rdata, mem_ready,
    input  busy, done, rf_read_index, rf_write_index, rf_write_data,
           rf_write_enable, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/reg_context_engine.sv
// rtl/reg_context_engine.sv - register-file context save/restore initiator
// Walks all registers between the register file and consecutive memory words.
module reg_context_engine #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_SHORT = 28,
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reg_context_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_REQ,
    REST_REQ,
    REST_WR,
    DONE
  } state_t;

  localparam logic [DATA_W-1:0] SHORT_MASK = DATA_W'((1 << 16) - 1);

  state_t            state;
  logic [4:0]        idx;
  logic [ADDR_W-1:0] base_q;
  logic              mode_q;
  logic [DATA_W-1:0] data_q;

  logic is_last;
  logic is_short;
  logic in_save;
  logic in_rest_req;
  logic in_rest_wr;

  assign is_last     = (int'(idx) == NUM_REGS - 1);
  assign is_short    = (int'(idx) < NUM_SHORT);
  assign in_save     = (state == SAVE_REQ);
  assign in_rest_req = (state == REST_REQ);
  assign in_rest_wr  = (state == REST_WR);

  function automatic logic [DATA_W-1:0] fit_width(input logic [DATA_W-1:0] d, input logic short_reg);
    fit_width = short_reg ? (d & SHORT_MASK) : d;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      base_q <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            base_q <= bus.base_addr;
            idx    <= '0;
            state  <= bus.mode ? REST_REQ : SAVE_REQ;
          end
        end
        SAVE_REQ: begin
          if (bus.mem_ready) begin
            if (is_last) state <= DONE;
            else         idx   <= idx + 5'd1;
          end
        end
        REST_REQ: begin
          if (bus.mem_ready) begin
            data_q <= bus.mem_rdata;
            state  <= REST_WR;
          end
        end
        REST_WR: begin
          if (is_last) begin
            state <= DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= REST_REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so reset forces them low at once.
  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.mem_we          = in_save && !mode_q;
  assign bus.mem_re          = in_rest_req && mode_q;
  assign bus.mem_addr        = (in_save || in_rest_req) ? (base_q + ADDR_W'(idx)) : '0;
  assign bus.rf_read_index   = in_save ? idx : 5'd0;
  assign bus.mem_wdata       = in_save ? fit_width(bus.rf_read_data, is_short) : '0;
  assign bus.rf_write_enable = in_rest_wr;
  assign bus.rf_write_index  = in_rest_wr ? idx : 5'd0;
  assign bus.rf_write_data   = in_rest_wr ? fit_width(data_q, is_short) : '0;

endmodule

// File: tb/tb_reg_context_engine.sv
// tb/tb_reg_context_engine.sv - directed self-checking bench for reg_context_engine
// Bench models the register file and a memory with configurable ready latency.
module tb_reg_context_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_context_engine_if bus ();

  reg_context_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [23:0] rf [32];
  logic [23:0] mem [logic [23:0]];
  int          wr_count [logic [23:0]];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        chk_stable = 1'b0;
  logic [23:0] hold_addr;
  logic [23:0] hold_wdata;
  int          tests = 0;
  int          fails = 0;

  assign bus.rf_read_data = rf[bus.rf_read_index];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [23:0] a);
    memrd = mem.exists(a) ? {8'h00, mem[a]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wrcnt(input logic [23:0] a);
    wrcnt = wr_count.exists(a) ? wr_count[a] : 0;
  endfunction

  function automatic logic [23:0] preload_val(input int i);
    preload_val = (i < 28) ? 24'h001000 + 24'(i) : 24'hAB0000 + 24'(i - 28);
  endfunction

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = preload_val(i);
  endtask

  // Memory and register-file write side, evaluated each falling edge.
  task automatic responder();
    forever begin
      @(negedge clk);
      if (bus.rf_write_enable) rf[bus.rf_write_index] = bus.rf_write_data;
      if (bus.mem_we || bus.mem_re) begin
        if (wait_cnt > 0 && chk_stable) begin
          check("stable_addr", {8'h0, bus.mem_addr}, {8'h0, hold_addr});
          check("stable_wdata", {8'h0, bus.mem_wdata}, {8'h0, hold_wdata});
          check("stable_we", {31'h0, bus.mem_we}, 32'h1);
        end
        if (wait_cnt == 0) begin
          hold_addr  = bus.mem_addr;
          hold_wdata = bus.mem_wdata;
        end
        if (wait_cnt < wait_cfg) begin
          bus.mem_ready = 1'b0;
          wait_cnt++;
        end else begin
          bus.mem_ready = 1'b1;
          wait_cnt = 0;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_count[bus.mem_addr] = wrcnt(bus.mem_addr) + 1;
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 24'h0;
          end
        end
      end else begin
        bus.mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic run_op(input logic m, input logic [23:0] base, output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    logic done_seen;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.base_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    preload();
    fork
      responder();
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_we_re", {30'h0, bus.mem_we, bus.mem_re}, 32'h0);
    check("rst_addr", {8'h0, bus.mem_addr}, 32'h0);
    check("rst_wdata", {8'h0, bus.mem_wdata}, 32'h0);
    check("rst_rf_we", {31'h0, bus.rf_write_enable}, 32'h0);
    check("rst_rf_wdata", {8'h0, bus.rf_write_data}, 32'h0);
    check("rst_rf_ridx", {27'h0, bus.rf_read_index}, 32'h0);
    reset_n = 1'b1;

    // Save with ready tied high.
    run_op(1'b0, 24'h000100, cyc);
    check("t1_done_cyc", cyc, 33);
    for (int i = 0; i < 32; i++) check($sformatf("t1_mem%0d", i), memrd(24'h100 + 24'(i)), {8'h0, preload_val(i)});
    check("t1_mem11C", memrd(24'h11C), 32'hAB0000);
    check("t1_mem11B", memrd(24'h11B), 32'h00101B);
    @(negedge clk);
    check("t1_idle_busy", {31'h0, bus.busy}, 32'h0);

    // Restore into a cleared register file.
    for (int i = 0; i < 32; i++) rf[i] = 24'h0;
    run_op(1'b1, 24'h000100, cyc);
    check("t2_done_cyc", cyc, 65);
    @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("t2_rf%0d", i), {8'h0, rf[i]}, {8'h0, preload_val(i)});
    mem[24'h105] = 24'hFF1234;
    run_op(1'b1, 24'h000100, cyc);
    @(negedge clk);
    check("t2_rf5_masked", {8'h0, rf[5]}, 32'h001234);
    check("t2_rf29_full", {8'h0, rf[29]}, 32'hAB0001);

    // Save with three wait cycles per request.
    preload();
    mem.delete();
    wr_count.delete();
    wait_cfg = 3;
    chk_stable = 1'b1;
    run_op(1'b0, 24'h000100, cyc);
    wait_cfg = 0;
    chk_stable = 1'b0;
    check("t3_done_cyc", cyc, 129);
    check("t3_nwrites", wr_count.num(), 32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t3_cnt%0d", i), wrcnt(24'h100 + 24'(i)), 1);
      check($sformatf("t3_mem%0d", i), memrd(24'h100 + 24'(i)), {8'h0, preload_val(i)});
    end

    // Address wrap past the top of memory.
    run_op(1'b0, 24'hFFFFF0, cyc);
    check("t4_done_cyc", cyc, 33);
    check("t4_memFFFFFF", memrd(24'hFFFFFF), 32'h00100F);
    check("t4_mem000000", memrd(24'h000000), 32'h001010);
    check("t4_mem00000F", memrd(24'h00000F), 32'hAB0003);

    // start while busy and in DONE is ignored; start in the next IDLE cycle is taken.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.base_addr = 24'h000200;
    @(negedge clk);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      bus.start = (cyc == 5);
      if (cyc == 5) begin
        bus.mode = 1'b1;
        bus.base_addr = 24'h000300;
      end
      @(negedge clk);
      cyc++;
    end
    check("t5_done_cyc", cyc, 33);
    check("t5_mem205", memrd(24'h205), 32'h001005);
    check("t5_mem21F", memrd(24'h21F), 32'hAB0003);
    mem[24'h31F] = 24'h123456;
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.base_addr = 24'h000400;
    @(negedge clk);
    check("t5_done_start_ign", {31'h0, bus.busy}, 32'h0);
    bus.base_addr = 24'h000300;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5_acc_busy", {31'h0, bus.busy}, 32'h1);
    check("t5_acc_re", {30'h0, bus.mem_we, bus.mem_re}, 32'h1);
    check("t5_acc_addr", {8'h0, bus.mem_addr}, 32'h000300);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_rest_cyc", cyc, 65);
    @(negedge clk);
    check("t5_rf31", {8'h0, rf[31]}, 32'h123456);

    // Reset in the middle of a restore.
    for (int i = 0; i < 32; i++) rf[i] = 24'h777777;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.base_addr = 24'h000100;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    done_seen = 1'b0;
    while (!(bus.mem_re && bus.mem_addr == 24'h10A) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.done) done_seen = 1'b1;
    end
    check("t6_reached_idx10", {31'h0, bus.mem_re}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("t6_rst_re", {31'h0, bus.mem_re}, 32'h0);
    check("t6_rst_addr", {8'h0, bus.mem_addr}, 32'h0);
    check("t6_rst_rf_we", {31'h0, bus.rf_write_enable}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("t6_idle_busy", {31'h0, bus.busy}, 32'h0);
    check("t6_no_done", {31'h0, done_seen}, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("t6_rf%0d", i), {8'h0, rf[i]}, (i < 10) ? {8'h0, preload_val(i)} : 32'h777777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
